// File: rtl/ska_pkg.sv
// Shared definitions for the Kogge-Stone adder slice: issue FSM states,
// a constant clog2 helper and the default operand width.
package ska_pkg;

  // Default operand width, shared with the PE array top.
  localparam int unsigned SkaWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } ska_state_e;

  // Constant-foldable ceil(log2(val)); returns 0 for val <= 1.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    longint unsigned pow;
    res = 0;
    pow = 1;
    while (pow < longint'(val)) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ska_pg_cell.sv
// Per-bit propagate/generate cell. Bit 0 folds the carry-in into its
// generate term so the prefix tree never needs a separate carry input.
module ska_pg_cell #(
  parameter bit FOLD_CIN = 1'b0
) (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic P,
  output logic G
);

  // Propagate is the half-sum; generate optionally absorbs the carry-in.
  always_comb begin
    P = A ^ B;
    G = (A & B) | (FOLD_CIN & P & CIN);
  end

endmodule

// File: rtl/ska_pg_issue.sv
// Operand issue and sequencing stage in front of the Kogge-Stone PE array.
// Registers the level-0 P/G vectors, clears the array, then freezes it after
// LEVELS settle cycles and pulses DONE once the array outputs are final.
module ska_pg_issue
  import ska_pkg::*;
#(
  parameter int unsigned WIDTH  = SkaWidth,
  parameter int unsigned LEVELS = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             CIN,
  output logic [WIDTH-1:0] PRP_OUT,
  output logic [WIDTH-1:0] GEN_OUT,
  output logic             ARRAY_RST,
  output logic             FINISHED,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CntW = (clog2(LEVELS) > 0) ? clog2(LEVELS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LEVELS - 1);

  // The array depth is fixed by the operand width; a mismatch is a build error.
  if (LEVELS != clog2(WIDTH)) begin : gen_levels_check
    $error("ska_pg_issue: LEVELS must equal ceil(log2(WIDTH))");
  end

  ska_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [WIDTH-1:0] prp_q, gen_q;
  logic [WIDTH-1:0] prp_d, gen_d;
  logic            array_rst_q;
  logic            finished_q;
  logic            done_q;
  logic            accept;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_cells
    ska_pg_cell #(
      .FOLD_CIN(i == 0)
    ) u_cell (
      .A  (A_IN[i]),
      .B  (B_IN[i]),
      .CIN(CIN),
      .P  (prp_d[i]),
      .G  (gen_d[i])
    );
  end

  // Ready decodes the state; array_rst_q masks the first IDLE cycle after reset.
  always_comb begin
    IN_READY = ((state_q == StIdle) & ~array_rst_q) | (state_q == StDone);
    BUSY     = (state_q == StLoad) | (state_q == StRun);
    accept   = IN_VALID & IN_READY;
  end

  // Issue FSM with level counter; strobes are registered from the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      prp_q       <= '0;
      gen_q       <= '0;
      array_rst_q <= 1'b1;
      finished_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      array_rst_q <= 1'b0;
      finished_q  <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            state_q     <= StLoad;
            array_rst_q <= 1'b1;
            prp_q       <= prp_d;
            gen_q       <= gen_d;
          end else begin
            state_q <= StIdle;
          end
        end
        StLoad: begin
          state_q    <= StRun;
          cnt_q      <= '0;
          finished_q <= (CntLast == '0);
        end
        StRun: begin
          if (cnt_q == CntLast) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + CntW'(1);
            finished_q <= ((cnt_q + CntW'(1)) == CntLast);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign PRP_OUT   = prp_q;
  assign GEN_OUT   = gen_q;
  assign ARRAY_RST = array_rst_q;
  assign FINISHED  = finished_q;
  assign DONE      = done_q;

endmodule

// File: doc/ska_pg_issue.md
Name: ska_pg_issue

Overview:
- Operand-issue and sequencing stage directly upstream of the Kogge-Stone prefix PE array.
- Accepts an A/B/carry-in operand set over a valid/ready handshake and registers the initial per-bit propagate and generate vectors that feed the first PE level.
- Clears the array between operations, holds the P/G vectors stable while the prefix tree settles, and drives the FINISHED freeze signal to all PEs after LEVELS cycles.
- Pulses DONE when the array outputs are final.

Parameters:
- WIDTH, 16, operand width in bits.
- LEVELS, 4, prefix levels in the array; must equal ceil(log2(WIDTH)), which is checked at elaboration.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operand set valid.
- IN_READY  output  1  stage can accept an operand set.
- A_IN  input  WIDTH  operand A.
- B_IN  input  WIDTH  operand B.
- CIN  input  1  carry-in.
- PRP_OUT  output  WIDTH  registered propagate vector to level-0 PRP_IN_CURR/PRP_IN_PREV.
- GEN_OUT  output  WIDTH  registered generate vector to level-0 GEN_IN.
- ARRAY_RST  output  1  synchronous active-high clear to all PEs.
- FINISHED  output  1  freeze strobe to all PEs.
- BUSY  output  1  operation in flight (LOAD or RUN).
- DONE  output  1  one-cycle pulse; PE outputs are final.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State goes to IDLE and the level counter to 0.
  - PRP_OUT=0, GEN_OUT=0, FINISHED=0, DONE=0, BUSY=0, IN_READY=0.
  - ARRAY_RST=1 for the whole reset period.
  - On the first clock edge after release: ARRAY_RST=0 and IN_READY=1.
- All outputs are registered except IN_READY and BUSY, which decode the current state.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - IN_READY=1.
  - If IN_VALID=1 at a clock edge, accept and go to LOAD.
  - On accept: PRP_OUT <= A_IN ^ B_IN.
  - On accept: GEN_OUT <= A_IN & B_IN, except bit 0 = (A0&B0) | ((A0^B0)&CIN).
- LOAD (1 cycle):
  - ARRAY_RST=1 so the PEs clear their IS_FINISHED latch.
  - IN_READY=0 and BUSY=1.
  - Next state is RUN with counter=0.
- RUN (exactly LEVELS cycles):
  - PRP_OUT/GEN_OUT are held constant and the counter increments each cycle.
  - FINISHED=1 only in the cycle where counter==LEVELS-1.
  - After that cycle, go to DONE.
- DONE (1 cycle):
  - DONE=1, FINISHED=0, BUSY=0, IN_READY=1.
  - An accept in DONE goes straight to LOAD (back-to-back); otherwise go to IDLE.
- Latency: accept at edge T gives LOAD in cycle T+1, RUN in T+2..T+1+LEVELS, FINISHED in T+1+LEVELS, and DONE in T+2+LEVELS.
- Throughput: one operation per LEVELS+2 cycles with back-to-back accepts.
- PRP_OUT/GEN_OUT keep the last operand after DONE until the next accept. The PE array stays frozen, so its results remain readable.
- IN_VALID and operand changes outside IDLE/DONE are ignored; there is no abort path.
- An RST_N assertion mid-RUN immediately forces IDLE and sets ARRAY_RST=1. DONE is never produced for the interrupted operation.
- CIN=1 with all-propagate operands (A^B all ones) is legal; the carry chains the full width.

Decomposition:
- Shared package ska_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - a clog2 constant function used for the LEVELS check and counter width;
  - the default WIDTH constant, which is shared with the PE array top.
- One sub-module is natural: ska_pg_cell, the per-bit combinational P/G generator with an optional carry-in fold, instantiated WIDTH times.
- The FSM and level counter stay inline.

Test Plan (WIDTH=16, LEVELS=4):
- Reset: hold RST_N=0 for 3 cycles with CLK running, then release.
  - During reset: ARRAY_RST=1, all other outputs 0.
  - One edge after release: IN_READY=1, ARRAY_RST=0.
- Basic issue: A=0x00FF, B=0x0001, CIN=0, accepted at edge T.
  - PRP_OUT=0x00FE, GEN_OUT=0x0001 in T+1.
  - ARRAY_RST=1 only in T+1.
  - FINISHED=1 only in T+5; DONE=1 only in T+6.
- Carry-in fold: A=0xFFFF, B=0x0000, CIN=1.
  - PRP_OUT=0xFFFF, GEN_OUT=0x0001.
  - The array sum reads 0x0000 at DONE.
- Back-to-back: IN_VALID held high with A=0x1234, B=0x1111, then A=0x8000, B=0x8000.
  - Second accept occurs in the DONE cycle; the next ARRAY_RST is in the following cycle.
  - Two DONE pulses 6 cycles apart.
- Stall: IN_VALID=1 with operand changes during RUN.
  - PRP_OUT/GEN_OUT stay unchanged and IN_READY=0 until DONE.
- Mid-operation reset: RST_N=0 asynchronously in RUN cycle 2.
  - Outputs clear immediately and ARRAY_RST=1.
  - No DONE pulse occurs; after release, a new issue completes normally.
